puf_response_packer: RTL

Downstream stage of the PUF measurement block. Consumes the per-loop oscillation counts strobed out by the PUF state machine, compares loops in adjacent pairs (2k vs 2k+1) to derive one response bit per pair plus a stability flag, packs the bits into fixed-width words and presents them on a valid/ready stream to the readout logic (UART/AXI bridge). Also raises a completion flag and sticky error flags for the host.

---
 rtl/puf_pkg.sv | 9 +
 rtl/puf_word_fifo.sv | 35 +++
 rtl/puf_response_packer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// puf_pkg: shared state type, word-index width and pair-difference helper for the PUF response packer.
package puf_pkg;
  localparam int WORD_INDEX_BITS = 16;
  localparam int DIFF_BITS = 64;
  typedef enum logic [2:0] {IDLE, WAIT_EVEN, WAIT_ODD, FLUSH, DRAIN, DONE} packer_state_t;
  function automatic logic [DIFF_BITS-1:0] abs_diff(input logic [DIFF_BITS-1:0] a, input logic [DIFF_BITS-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction
endpackage

// File: rtl/puf_word_fifo.sv
// puf_word_fifo: small synchronous FIFO for packed response words; drops pushes when full unless popped the same cycle.
module puf_word_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(do_push);
      rd_ptr <= rd_ptr + (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/puf_response_packer.sv
// puf_response_packer: compares adjacent PUF loop counts into response/stability bits and streams packed words.
module puf_response_packer
  import puf_pkg::*;
#(
  parameter int NUM_LOOPS = 1280,
  parameter int TOT_CNT_BITS = 32,
  parameter int WORD_BITS = 32,
  parameter int THRESHOLD = 16,
  parameter int FIFO_DEPTH = 2,
  localparam int LN_BITS = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       store_response_puf,
  input  logic [TOT_CNT_BITS-1:0]    loop_response,
  input  logic [LN_BITS-1:0]         loop_number,
  input  logic                       puf_done,
  output logic [WORD_BITS-1:0]       resp_word,
  output logic [WORD_BITS-1:0]       mask_word,
  output logic [WORD_INDEX_BITS-1:0] word_index,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic                       all_done,
  output logic                       overflow,
  output logic                       seq_error
);
  localparam int PB = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int DW = WORD_INDEX_BITS + 2*WORD_BITS;
  localparam int LIMIT = 2*(NUM_LOOPS/2);
  packer_state_t state;
  logic [TOT_CNT_BITS-1:0] held_cnt;
  logic [LN_BITS-1:0] held_idx;
  logic [PB-1:0] bit_pos;
  logic [PB:0] fill;
  logic [WORD_BITS-1:0] resp_acc, mask_acc, resp_n, mask_n, pad;
  logic [WORD_INDEX_BITS-1:0] word_cnt;
  logic [DW-1:0] fifo_out;
  logic cmp_valid, cmp_bit, cmp_unst, done_q, done_rise, in_range, last, push, pop, full, empty, strobe;
  assign done_rise = puf_done && !done_q;
  assign in_range = 32'(loop_number) < 32'(LIMIT);
  assign strobe = store_response_puf && in_range;
  assign last = cmp_valid && bit_pos == PB'(WORD_BITS-1);
  assign push = last || (state == FLUSH && fill != '0);
  assign pop = word_valid && word_ready;
  // The bit from the registered comparator is merged here so a flush can include it in the same cycle.
  always_comb begin
    resp_n = resp_acc;
    mask_n = mask_acc;
    pad = '0;
    if (cmp_valid) begin
      resp_n[bit_pos] = cmp_bit;
      mask_n[bit_pos] = cmp_unst;
    end
    fill = {1'b0, bit_pos} + (PB+1)'(cmp_valid);
    for (int i = 0; i < WORD_BITS; i++) pad[i] = (PB+1)'(i) >= fill;
  end
  always_ff @(posedge clk) begin
    done_q <= reset ? 1'b0 : puf_done;
    if (reset || start) begin
      state <= reset ? IDLE : WAIT_EVEN;
      held_cnt <= '0;
      held_idx <= '0;
      bit_pos <= '0;
      resp_acc <= '0;
      mask_acc <= '0;
      word_cnt <= '0;
      cmp_valid <= 1'b0;
      cmp_bit <= 1'b0;
      cmp_unst <= 1'b0;
      all_done <= 1'b0;
      overflow <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      cmp_valid <= 1'b0;
      if (push) begin
        resp_acc <= '0;
        mask_acc <= '0;
        bit_pos <= '0;
        word_cnt <= word_cnt + 1'b1;
        overflow <= overflow || (full && !pop);
      end else if (cmp_valid) begin
        resp_acc <= resp_n;
        mask_acc <= mask_n;
        bit_pos <= bit_pos + 1'b1;
      end
      case (state)
        WAIT_EVEN:
          if (strobe) begin
            if (!loop_number[0]) begin
              held_cnt <= loop_response;
              held_idx <= loop_number;
              state <= WAIT_ODD;
            end else seq_error <= 1'b1;
          end
        WAIT_ODD:
          if (strobe) begin
            if (!loop_number[0]) begin
              held_cnt <= loop_response;
              held_idx <= loop_number;
              seq_error <= 1'b1;
            end else if (loop_number == held_idx + 1'b1) begin
              cmp_valid <= 1'b1;
              cmp_bit <= held_cnt > loop_response;
              cmp_unst <= abs_diff(DIFF_BITS'(held_cnt), DIFF_BITS'(loop_response)) < DIFF_BITS'(THRESHOLD);
              state <= WAIT_EVEN;
            end else seq_error <= 1'b1;
          end
        FLUSH: state <= DRAIN;
        DRAIN:
          if (empty) begin
            state <= DONE;
            all_done <= 1'b1;
          end
        default: ;
      endcase
      if ((state == WAIT_EVEN || state == WAIT_ODD) && done_rise) state <= FLUSH;
    end
  end
  puf_word_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .clear(start),
    .push(push),
    .pop(pop),
    .din({word_cnt, mask_n | pad, resp_n}),
    .dout(fifo_out),
    .full(full),
    .empty(empty)
  );
  assign word_valid = !empty;
  assign {word_index, mask_word, resp_word} = empty ? '0 : fifo_out;
endmodule
